reg_file_32: RTL
================

# reg_file_32

Architectural general-purpose register file for the single-cycle MIPS datapath: 32 registers × 32 bits, two asynchronous read ports (rs, rt) and one synchronous write port. It directly feeds the execute stage: the rt read port supplies the shift operand to the 32-bit left shifter, and the ALU and shifter results return through the write port. Register $0 is hardwired to zero.

## Interface
- DATA_W, 32, register width. Only 32 is supported; the parameter exists for lint/checks.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears every register to 0.
- rs_addr  input  5  read port A address (instr[25:21]).
- rt_addr  input  5  read port B address (instr[20:16]).
- rs_data  output  32  contents of register rs_addr.
- rt_data  output  32  contents of register rt_addr; feeds the shifter's rt operand.
- we  input  1  write enable for the current cycle.
- wr_addr  input  5  write address (rd or rt, selected upstream by RegDst).
- wr_data  input  32  write data (ALU/shifter/memory result, selected upstream).

## Operation
- Storage: registers 1..31 as flops, 32 bits each; register 0 is not stored.
- Read ports: purely combinational. rs_data = (rs_addr==0) ? 0 : reg[rs_addr]; same rule for rt_data.
- Write: on rising clk, if we=1, rst_n=1 and wr_addr≠0, then reg[wr_addr] ← wr_data.
- Writes with wr_addr=0 are discarded; reads of $0 always return 32'h0000_0000.
- we=0: no register changes, regardless of wr_addr/wr_data.
- Both read ports may address the same register; both return the identical value.
- No X propagation: after reset every register reads 0 until written.

## Timing
- Read latency 0 cycles (combinational from address and register state).
- Write latency 1 edge: the value written at edge N is visible on the read ports immediately after edge N.
- Same-cycle read/write of the same nonzero address (without bypass): the read returns the old value before the edge and the new value after it.
- Reset: rst_n low clears all registers immediately, without waiting for clk. While rst_n=0 every read returns 0, and writes are ignored even with we=1 at a clock edge.
- Reset deassertion: the first write can occur at the first rising clk with rst_n=1.
- Reset mid-operation: any write due at a concurrent edge is lost. State is all-zero after release.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding. When we=1, wr_addr≠0 and a read address equals wr_addr, that port returns wr_data combinationally in the same cycle, before the edge. The $0 rule still wins, and bypass is disabled while rst_n=0.
- REGFILE_BYPASS_EN undefined: no forwarding. Read ports reflect stored state only, as described in Timing.

## Test plan
- Reset: hold rst_n=0 with we=1, wr_addr=5, wr_data=32'hDEAD_BEEF for 3 edges, then release. Required: rs_data/rt_data read 0 for every address 0..31.
- Write/readback: write reg[i]=32'h1000_0000+i for i=1..31 on successive edges. Required: sweeping rs_addr and rt_addr returns the matching values on both ports.
- $0 immutability: we=1, wr_addr=0, wr_data=32'hFFFF_FFFF at one edge. Required: rs_addr=0 and rt_addr=0 both read 0.
- Shift feed: write reg[9]=32'h0000_0001 and set rt_addr=9. Required: rt_data=32'h0000_0001 and the downstream shifter with shamt=31 yields 32'h8000_0000. With we=0 and wr_data changing, rt_data stays unchanged.
- Same-cycle read/write: reg[3]=32'hAAAA_AAAA, then we=1, wr_addr=3, wr_data=32'h5555_5555, rs_addr=3.
  - Required before the edge: rs_data=32'hAAAA_AAAA without the macro, 32'h5555_5555 with REGFILE_BYPASS_EN.
  - Required after the edge: 32'h5555_5555 in both builds.
- Async reset mid-run: with registers populated, pulse rst_n low between clock edges. Required: all reads go to 0 immediately, before the next clk edge, and stay 0 after release until written.

Source files
------------

// File: rtl/reg_file_32.sv
// reg_file_32: 32 x 32-bit MIPS register file, two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward the pending write data to matching read ports.
module reg_file_32 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_q [1:31];
    logic [DATA_W-1:0] regs_d [1:31];
    logic [DATA_W-1:0] rd_view [32];
    logic              wr_valid;
    logic              rs_fwd;
    logic              rt_fwd;

    assign wr_valid = we && (wr_addr != 5'd0);

    always_comb begin
        // NOTE: start from the current state so every path assigns regs_d and no latch is inferred.
        regs_d = regs_q;
        if (wr_valid) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // NOTE: every register is reset, so reads never return X before the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Full 32-entry view with $0 tied low, so a 5-bit address indexes it without range gaps.
    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rd_view[i] = regs_q[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rs_fwd = rst_n && wr_valid && (rs_addr == wr_addr);
    assign rt_fwd = rst_n && wr_valid && (rt_addr == wr_addr);
`else
    assign rs_fwd = 1'b0;
    assign rt_fwd = 1'b0;
`endif

    always_comb begin
        rs_data = rd_view[rs_addr];
        rt_data = rd_view[rt_addr];
        if (rs_fwd) begin
            rs_data = wr_data;
        end
        if (rt_fwd) begin
            rt_data = wr_data;
        end
        if (rs_addr == 5'd0) begin
            rs_data = '0;
        end
        if (rt_addr == 5'd0) begin
            rt_data = '0;
        end
    end

endmodule
